// File: rtl/glitch_monitor_mc_if.sv
// rtl/glitch_monitor_mc_if.sv - control, sampled-signal and status bundle for glitch_monitor_mc
// master drives configuration and monitored signals; slave is the monitor itself.
interface glitch_monitor_mc_if #(
   parameter int NCH   = 8,
   parameter int CNTW  = 8,
   parameter int ERRCW = 16
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

   logic             dis;
   logic [NCH-1:0]   ch_en;
   logic [NCH-1:0]   pol;
   logic [NCH-1:0]   din;
   logic [CNTW-1:0]  min_width;
   logic [CNTW-1:0]  max_width;
   logic             err_clr;
   logic [NCH-1:0]   err_short;
   logic [NCH-1:0]   err_long;
   logic             err;
   logic [ERRCW-1:0] err_cnt;
   logic             first_valid;
   logic [CHW-1:0]   first_ch;
   logic [CNTW-1:0]  first_width;
   logic             first_long;

   modport master (
      output dis, ch_en, pol, din, min_width, max_width, err_clr,
      input  err_short, err_long, err, err_cnt, first_valid, first_ch, first_width, first_long
   );

   modport slave (
      input  dis, ch_en, pol, din, min_width, max_width, err_clr,
      output err_short, err_long, err, err_cnt, first_valid, first_ch, first_width, first_long
   );
endinterface

// File: rtl/glitch_monitor_mc.sv
// rtl/glitch_monitor_mc.sv - multi-channel pulse-width monitor with sticky status
// Each channel measures active pulses in clk cycles and flags short/long ones.
module glitch_monitor_mc #(
   parameter int NCH         = 8,
   parameter int CNTW        = 8,
   parameter int ERRCW       = 16,
   parameter int SYNC_STAGES = 2
) (
   input logic               i_clk,
   input logic               i_rst_n,
   glitch_monitor_mc_if.slave io_mon
);
   localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int SUMW = ((ERRCW > 8) ? ERRCW : 8) + 1;

   typedef enum logic [1:0] {S_DISARM = 2'd0, S_IDLE = 2'd1, S_ACTIVE = 2'd2} state_t;

   logic [NCH-1:0]   w_din_s, w_act, w_run, w_short, w_long;
   logic             w_any;
   state_t           r_state     [NCH];
   state_t           w_state_nxt [NCH];
   logic [CNTW-1:0]  r_cnt       [NCH];
   logic [CNTW-1:0]  w_cnt_nxt   [NCH];
   logic [NCH-1:0]   r_err_short, r_err_long;
   logic [ERRCW-1:0] r_err_cnt, w_cnt_base, w_cnt_sat;
   logic [SUMW-1:0]  w_sum;
   logic [7:0]       w_nev;
   logic             r_first_valid, r_first_long, w_cap_long;
   logic [CHW-1:0]   r_first_ch, w_cap_ch;
   logic [CNTW-1:0]  r_first_width, w_cap_width;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign w_din_s = io_mon.din;
      end else begin : g_sync
         logic [NCH-1:0] r_sync [SYNC_STAGES];
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
            end else begin
               r_sync[0] <= io_mon.din;
               for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
            end
         end
         assign w_din_s = r_sync[SYNC_STAGES-1];
      end
   endgenerate

   assign w_act = w_din_s ^ io_mon.pol;
   assign w_run = {NCH{~io_mon.dis}} & io_mon.ch_en;
   assign w_any = (|w_short) | (|w_long);

   // Long fires on the cycle cnt steps from max_width to max_width+1, so only once per pulse.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         w_state_nxt[i] = r_state[i];
         w_cnt_nxt[i]   = r_cnt[i];
         w_short[i]     = 1'b0;
         w_long[i]      = 1'b0;
         if (!w_run[i]) begin
            w_state_nxt[i] = S_DISARM;
            w_cnt_nxt[i]   = '0;
         end else begin
            case (r_state[i])
               S_DISARM: if (!w_act[i]) w_state_nxt[i] = S_IDLE;
               S_IDLE: begin
                  if (w_act[i]) begin
                     w_state_nxt[i] = S_ACTIVE;
                     w_cnt_nxt[i]   = CNTW'(1);
                  end
               end
               S_ACTIVE: begin
                  if (w_act[i]) begin
                     if (r_cnt[i] != '1) w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                     w_long[i] = (io_mon.max_width != '0) && (r_cnt[i] == io_mon.max_width) &&
                                 (r_cnt[i] != '1);
                  end else begin
                     w_short[i]     = (io_mon.min_width != '0) && (r_cnt[i] < io_mon.min_width);
                     w_state_nxt[i] = S_IDLE;
                     w_cnt_nxt[i]   = '0;
                  end
               end
               default: w_state_nxt[i] = S_DISARM;
            endcase
         end
      end
   end

   // Descending scan: lowest channel wins, and short beats long on one channel.
   always_comb begin
      w_nev       = '0;
      w_cap_ch    = '0;
      w_cap_width = '0;
      w_cap_long  = 1'b0;
      for (int i = 0; i < NCH; i++) w_nev = w_nev + 8'(w_short[i]) + 8'(w_long[i]);
      for (int i = NCH - 1; i >= 0; i--) begin
         if (w_short[i] || w_long[i]) begin
            w_cap_ch    = CHW'(i);
            w_cap_long  = ~w_short[i];
            w_cap_width = w_short[i] ? r_cnt[i] : io_mon.max_width + 1'b1;
         end
      end
      w_cnt_base = io_mon.err_clr ? '0 : r_err_cnt;
      w_sum      = SUMW'(w_cnt_base) + SUMW'(w_nev);
      w_cnt_sat  = (w_sum > SUMW'({ERRCW{1'b1}})) ? '1 : w_sum[ERRCW-1:0];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            r_state[i] <= S_DISARM;
            r_cnt[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            r_state[i] <= w_state_nxt[i];
            r_cnt[i]   <= w_cnt_nxt[i];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_err_short   <= '0;
         r_err_long    <= '0;
         r_err_cnt     <= '0;
         r_first_valid <= 1'b0;
         r_first_ch    <= '0;
         r_first_width <= '0;
         r_first_long  <= 1'b0;
      end else begin
         r_err_short <= (io_mon.err_clr ? '0 : r_err_short) | w_short;
         r_err_long  <= (io_mon.err_clr ? '0 : r_err_long) | w_long;
         r_err_cnt   <= w_cnt_sat;
         if ((io_mon.err_clr || !r_first_valid) && w_any) begin
            r_first_valid <= 1'b1;
            r_first_ch    <= w_cap_ch;
            r_first_width <= w_cap_width;
            r_first_long  <= w_cap_long;
         end else if (io_mon.err_clr) begin
            r_first_valid <= 1'b0;
            r_first_ch    <= '0;
            r_first_width <= '0;
            r_first_long  <= 1'b0;
         end
      end
   end

   assign io_mon.err_short   = r_err_short;
   assign io_mon.err_long    = r_err_long;
   assign io_mon.err         = (|r_err_short) | (|r_err_long);
   assign io_mon.err_cnt     = r_err_cnt;
   assign io_mon.first_valid = r_first_valid;
   assign io_mon.first_ch    = r_first_ch;
   assign io_mon.first_width = r_first_width;
   assign io_mon.first_long  = r_first_long;
endmodule

// File: doc/glitch_monitor_mc.md
Name: glitch_monitor_mc

Overview:
- Synthesizable, multi-channel pulse-width monitor. Successor to the single-channel behavioural glitch checker.
- Samples NCH single-bit signals on one clock and measures every active pulse in clock cycles.
- Flags pulses shorter than a runtime minimum or longer than a runtime maximum, with sticky per-channel status, a saturating error count and first-error capture.
- Instanced in bench checkers and in DFT/debug logic next to PHY control strobes.

Parameters:
- NCH, 8, number of monitored channels (1..32).
- CNTW, 8, pulse-width counter and threshold width in bits.
- ERRCW, 16, width of the global error counter.
- SYNC_STAGES, 2, synchroniser flops per din bit; 0 = din used directly (already synchronous).

Ports:
- clk  in  1  sampling clock.
- rst  in  1  asynchronous active-low reset.
- dis  in  1  global disable; 1 freezes detection, status is held.
- ch_en  in  NCH  per-channel enable.
- pol  in  NCH  per-channel polarity; 0 = high active, 1 = low active.
- din  in  NCH  monitored signals.
- min_width  in  CNTW  a pulse with width < min_width is short; 0 disables the check.
- max_width  in  CNTW  a pulse with width > max_width is long; 0 disables the check.
- err_clr  in  1  single-cycle clear of all status.
- err_short  out  NCH  sticky short-pulse flags.
- err_long  out  NCH  sticky long-pulse flags.
- err  out  1  OR of all sticky flags.
- err_cnt  out  ERRCW  saturating count of error events.
- first_valid  out  1  first-error capture is valid.
- first_ch  out  $clog2(NCH) (min 1)  channel of the first error.
- first_width  out  CNTW  measured width of the first error (for long errors: max_width+1).
- first_long  out  1  first error was long (1) or short (0).

Behaviour:
- Reset (rst=0, async): all outputs 0, all counters 0, every channel FSM in DISARM, synchroniser flops 0.
- Sampling: din_s = din after SYNC_STAGES flops. act = din_s ^ pol per channel.
- Channel FSM; all transitions happen on posedge clk while run = ~dis & ch_en[i]:
  - DISARM: go to IDLE on the first cycle where act = 0. This prevents partial-pulse false errors after reset or enable.
  - IDLE: if act = 1, go to ACTIVE and set cnt = 1.
  - ACTIVE, act = 1: cnt = cnt + 1, saturating at 2^CNTW-1.
  - ACTIVE, act = 0: the width is cnt. If min_width != 0 and cnt < min_width, raise a short event. Go to IDLE.
  - ACTIVE, long check: if max_width != 0 and the incremented cnt equals max_width+1, raise a long event. This fires once per pulse, while the pulse is still active.
- If run = 0, the FSM is forced to DISARM and cnt is held at 0. Dropping enable mid-pulse discards that pulse with no error.
- Event timing: the flag is set at the same clk edge that samples the terminating inactive level (short) or the (max_width+1)-th active level (long). Latency from a din edge = SYNC_STAGES + 1 cycles.
- Sticky flags: err_short[i] and err_long[i] stay set until err_clr. Flags are registered; err is the combinational OR of the flag registers.
- err_cnt: adds the number of events in the cycle (popcount across both types and all channels). Saturates at all-ones.
- First capture: loads only when first_valid = 0 and at least one event occurs. If several events coincide, the lowest channel index wins; on the same channel, short wins over long.
- err_clr: clears flags, err_cnt and first_valid. An event in the same cycle as err_clr wins: the flag is set, err_cnt = its event count, and the capture loads. FSMs and pulse counters are not affected.
- Threshold changes take effect on the next comparison. No pulse is re-evaluated.
- A pulse that ends with width > max_width gives no second event at its end.

Test Plan:
- Reset, then all channels inactive for 4 cycles, then ch3 (pol=0) high for 1 cycle with min_width=2 -> err_short=0x08 exactly SYNC_STAGES+1 cycles after the din fall, err_cnt=1, first_ch=3, first_width=1, first_long=0.
- ch0 pol=1 low for 6 cycles with max_width=4 -> err_long[0]=1 while ch0 is still low, on the 5th active sample; err_cnt=1; no further event when the pulse ends.
- ch1 and ch5 both 1-cycle pulses in the same cycle -> err_cnt=2, first_ch=1. Then err_clr -> all status 0. Next glitch on ch5 -> first_ch=5.
- din ch2 held active through reset release and enable -> no error until it goes inactive then active again (DISARM check). Toggling ch_en[2] low mid-pulse -> no error.
- err_clr asserted in the same cycle as a ch4 short event -> err_short=0x10, err_cnt=1, first_valid=1.
- ERRCW=2, 5 glitches -> err_cnt saturates at 3. rst asserted mid-pulse -> all outputs 0 immediately, without waiting for clk.
